poly_add_ctrl: RTL and testbench
================================

POLY_ADD_CTRL -- requirements
Module: poly_add_ctrl

Interface
REQ-001 Parameter N_COEFF, default 256, SHALL be the number of coefficients per polynomial; legal values are powers of two from 2 to 256.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous and active-high.
REQ-004 start_i  input  1  SHALL request one full polynomial addition.
REQ-005 busy_o  output  1  SHALL indicate that an operation is in progress.
REQ-006 done_o  output  1  SHALL be a one-cycle completion pulse.
REQ-007 rd_en_o  output  1  SHALL be the read strobe to both operand memories.
REQ-008 rd_addr_o  output  $clog2(N_COEFF)  SHALL be the shared read address for both operand memories.
REQ-009 op1_rdata_i  input  12 (coeff_t)  SHALL carry operand A read data, valid exactly 1 cycle after rd_en_o.
REQ-010 op2_rdata_i  input  12 (coeff_t)  SHALL carry operand B read data, valid exactly 1 cycle after rd_en_o.
REQ-011 wr_en_o  output  1  SHALL be the result memory write strobe.
REQ-012 wr_addr_o  output  $clog2(N_COEFF)  SHALL be the result write address.
REQ-013 wr_data_o  output  12 (coeff_t)  SHALL be the result coefficient, equal to (op1 + op2) mod Q.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, READ, DRAIN, DONE.
REQ-015 IDLE SHALL go to READ on the edge where start_i=1; start_i SHALL be ignored in every other state.
REQ-016 READ SHALL last exactly N_COEFF cycles, with rd_en_o=1 and rd_addr_o = 0, 1, ..., N_COEFF-1 in consecutive cycles; after rd_addr_o=N_COEFF-1 the FSM SHALL go to DRAIN.
REQ-017 DRAIN SHALL last 1 cycle with rd_en_o=0; DONE SHALL last 1 cycle with done_o=1, then return to IDLE.
REQ-018 busy_o SHALL be 1 in READ and DRAIN, and 0 in IDLE and DONE.
REQ-019 wr_en_o and wr_addr_o SHALL be registered copies of rd_en_o and rd_addr_o, delayed by exactly 1 cycle.
REQ-020 wr_data_o SHALL be combinational from op1_rdata_i and op2_rdata_i through the adder, with 0 added latency; it is don't-care when wr_en_o=0.
REQ-021 Total latency SHALL be fixed: with start sampled at edge E, first write at E+2, last write at E+N_COEFF+1, and done_o high in cycle E+N_COEFF+2.
REQ-022 Exactly N_COEFF writes SHALL occur per operation, each address exactly once, in ascending order, with no gaps.
REQ-023 The address counter SHALL NOT wrap: rd_addr_o SHALL hold 0 outside READ.
REQ-024 start_i held high continuously SHALL start a new operation only from IDLE, i.e. back-to-back operations are spaced N_COEFF+3 cycles apart.
REQ-025 Arithmetic SHALL be a 13-bit sum with one conditional subtraction of Q=3329; inputs are required to be canonical (<Q), and behaviour for non-canonical inputs is unspecified.

Reset
REQ-026 While rst=1, the FSM SHALL enter IDLE and clear the counter, and every output SHALL be 0 on the following edge.
REQ-027 Reset asserted mid-operation SHALL abort it: no further wr_en_o pulses after the reset edge, and no done_o pulse.
REQ-028 start_i sampled in the same cycle as rst=1 SHALL be ignored.

Structure
REQ-029 coeff_t and Q SHALL come from poly_arith_pkg; the FSM state enum SHALL be defined locally.
REQ-030 The block SHALL instantiate exactly one mod_add sub-module for the datapath and contain no other arithmetic.
REQ-031 Operand and result memories SHALL be external to this block.

Verification
REQ-032 N_COEFF=256, A[i]=i, B[i]=0, start one cycle -> 256 writes with wr_data=i at wr_addr=i; done_o at start edge+258.
REQ-033 A[i]=3328, B[i]=3328 for all i -> every write = 3327; A[i]=3328, B[i]=1 -> every write = 0.
REQ-034 start_i pulsed at READ cycles 10 and 100 -> no effect: exactly 256 writes and one done_o pulse.
REQ-035 rst asserted at the 50th READ cycle -> at most 51 writes total, addresses 0..50 only, no done_o, all outputs 0 the next cycle; a subsequent start completes normally.
REQ-036 start_i held high for 600 cycles -> operations begin every 259 cycles, and each done_o is exactly 1 cycle wide.
REQ-037 Random canonical A and B (seeded), 3 operations, checked against a golden (a+b)%3329 scoreboard -> zero mismatches, and wr_en_o high exactly 768 cycles.

Source files
------------

// File: rtl/poly_arith_pkg.sv
// Shared arithmetic types for the polynomial datapath: coefficient width and modulus.
package poly_arith_pkg;
    localparam int unsigned COEFF_W = 12;
    localparam int unsigned Q       = 3329;

    typedef logic [COEFF_W-1:0] coeff_t;
endpackage

// File: rtl/mod_add.sv
// Modular adder: (a + b) mod Q for canonical operands, one conditional subtract.
module mod_add
    import poly_arith_pkg::*;
(
    input  coeff_t a,
    input  coeff_t b,
    output coeff_t sum
);
    logic [COEFF_W:0] raw;
    logic [COEFF_W:0] red;

    assign raw = {1'b0, a} + {1'b0, b};
    assign red = raw - (COEFF_W+1)'(Q);
    assign sum = (raw >= (COEFF_W+1)'(Q)) ? red[COEFF_W-1:0] : raw[COEFF_W-1:0];
endmodule

// File: rtl/poly_add_ctrl.sv
// Streams two operand memories through a mod-Q adder into a result memory, one
// coefficient per cycle; the write side trails the read side by one cycle.
//
// state | meaning
// IDLE  | waiting for start_i
// READ  | issuing reads for addresses 0..N_COEFF-1
// DRAIN | last read data returning, final write in flight
// DONE  | one-cycle completion pulse
module poly_add_ctrl
    import poly_arith_pkg::*;
#(
    parameter  int N_COEFF = 256,
    localparam int AW      = $clog2(N_COEFF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    input  coeff_t        op1_rdata_i,
    input  coeff_t        op2_rdata_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output coeff_t        wr_data_o
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    coeff_t        sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_en_q   <= rd_en_o;
            wr_addr_q <= rd_addr_o;
        end
    end

    // Address returns to zero on leaving READ so it never wraps into a new pass.
    always_comb begin
        state_d = state_q;
        addr_d  = '0;
        rd_en_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = READ;
            end
            READ: begin
                rd_en_o = 1'b1;
                busy_o  = 1'b1;
                if (addr_q == AW'(N_COEFF-1)) state_d = DRAIN;
                else                          addr_d  = addr_q + AW'(1);
            end
            DRAIN: begin
                busy_o  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_addr_o = addr_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;

    mod_add u_mod_add (
        .a   (op1_rdata_i),
        .b   (op2_rdata_i),
        .sum (sum)
    );

    // Gate the result so the data bus reads zero whenever no write is in progress.
    assign wr_data_o = wr_en_q ? sum : '0;
endmodule

// File: tb/tb_poly_add_ctrl.sv
// Directed bench for poly_add_ctrl: operand memories modelled here, writes
// checked against (a+b)%3329 and against fixed latency and ordering rules.
module tb_poly_add_ctrl;
    localparam int N  = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, rd_en_o, wr_en_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [11:0]   op1_rdata_i = '0, op2_rdata_i = '0, wr_data_o;

    poly_add_ctrl #(.N_COEFF(N)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .op1_rdata_i(op1_rdata_i),
        .op2_rdata_i(op2_rdata_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o)
    );

    always #5 clk = ~clk;

    logic [11:0] mem_a [N];
    logic [11:0] mem_b [N];
    logic [11:0] res   [N];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en_o) begin
            op1_rdata_i <= mem_a[rd_addr_o];
            op2_rdata_i <= mem_b[rd_addr_o];
        end
    end

    int wr_total = 0, data_err = 0, order_err = 0, done_total = 0, wide_err = 0;
    int first_wr_cyc = 0, last_wr_cyc = 0, done_cyc = 0;
    int busy_rise[$];
    logic          prev_wr = 1'b0, prev_done = 1'b0, prev_busy = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (wr_en_o) begin
            wr_total++;
            if (!prev_wr) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            if (prev_wr ? (wr_addr_o != prev_addr + AW'(1)) : (wr_addr_o != '0)) order_err++;
            if (int'(wr_data_o) != (int'(mem_a[wr_addr_o]) + int'(mem_b[wr_addr_o])) % 3329)
                data_err++;
            res[wr_addr_o] = wr_data_o;
        end
        if (done_o) begin
            done_total++;
            done_cyc = cyc;
            if (prev_done) wide_err++;
        end
        if (busy_o && !prev_busy) busy_rise.push_back(cyc);
        prev_wr   = wr_en_o;
        prev_addr = wr_addr_o;
        prev_done = done_o;
        prev_busy = busy_o;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic run_op(output int e);
        @(negedge clk) start_i = 1'b1;
        @(posedge clk);
        #1 e = cyc;
        @(negedge clk) start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && done_total < target; i++) @(negedge clk);
        chk(tag, int'(done_total >= target), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   int'(busy_o), 0);
        chk({tag, "_done"},   int'(done_o), 0);
        chk({tag, "_rden"},   int'(rd_en_o), 0);
        chk({tag, "_rdaddr"}, int'(rd_addr_o), 0);
        chk({tag, "_wren"},   int'(wr_en_o), 0);
        chk({tag, "_wraddr"}, int'(wr_addr_o), 0);
        chk({tag, "_wrdata"}, int'(wr_data_o), 0);
    endtask

    task automatic full_op(input string tag);
        int e, w0, d0, de0, oe0, wd0;
        w0 = wr_total; d0 = done_total; de0 = data_err; oe0 = order_err; wd0 = wide_err;
        run_op(e);
        wait_done({tag, "_timeout"}, d0 + 1, N + 20);
        repeat (2) @(negedge clk);
        chk({tag, "_writes"},   wr_total - w0, N);
        chk({tag, "_data"},     data_err - de0, 0);
        chk({tag, "_order"},    order_err - oe0, 0);
        chk({tag, "_first_wr"}, first_wr_cyc - e, 1);
        chk({tag, "_last_wr"},  last_wr_cyc - e, N);
        chk({tag, "_done_lat"}, done_cyc - e, N + 1);
        chk({tag, "_done_cnt"}, done_total - d0, 1);
        chk({tag, "_done_w"},   wide_err - wd0, 0);
    endtask

    initial begin
        int e, w0, d0, n0, oe0;
        void'($urandom(32'd20240611));

        // reset with start high must be ignored
        start_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk) start_i = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy_o), 0);

        for (int i = 0; i < N; i++) begin mem_a[i] = 12'(i); mem_b[i] = '0; end
        full_op("ramp");
        chk("ramp_res0", int'(res[0]), 0);
        chk("ramp_res255", int'(res[255]), 255);

        for (int i = 0; i < N; i++) begin mem_a[i] = 12'd3328; mem_b[i] = 12'd3328; end
        full_op("max");
        chk("max_res7", int'(res[7]), 3327);

        for (int i = 0; i < N; i++) begin mem_a[i] = 12'd3328; mem_b[i] = 12'd1; end
        full_op("wrapq");
        chk("wrapq_res9", int'(res[9]), 0);

        // stray starts during READ
        for (int i = 0; i < N; i++) begin mem_a[i] = 12'(3000 + (i % 200)); mem_b[i] = 12'(i); end
        w0 = wr_total; d0 = done_total;
        run_op(e);
        while (cyc < e + 9) @(negedge clk);
        start_i = 1'b1; @(negedge clk); start_i = 1'b0;
        while (cyc < e + 99) @(negedge clk);
        start_i = 1'b1; @(negedge clk); start_i = 1'b0;
        wait_done("stray_timeout", d0 + 1, N + 20);
        repeat (10) @(negedge clk);
        chk("stray_writes", wr_total - w0, N);
        chk("stray_done", done_total - d0, 1);
        chk("stray_busy", int'(busy_o), 0);

        // reset during READ aborts the operation
        w0 = wr_total; d0 = done_total; oe0 = order_err;
        run_op(e);
        while (cyc < e + 49) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 chk_all_zero("abort");
        @(negedge clk) rst = 1'b0;
        repeat (N + 10) @(negedge clk);
        chk("abort_le51", int'(wr_total - w0 <= 51), 1);
        chk("abort_order", order_err - oe0, 0);
        chk("abort_done", done_total - d0, 0);
        full_op("after_abort");

        // start held high: back-to-back operations every N+3 cycles
        n0 = busy_rise.size(); w0 = wr_total; d0 = done_total;
        @(negedge clk) start_i = 1'b1;
        repeat (600) @(negedge clk);
        start_i = 1'b0;
        wait_done("held_timeout", d0 + 3, 2 * N);
        repeat (5) @(negedge clk);
        chk("held_ops", busy_rise.size() - n0, 3);
        if (busy_rise.size() - n0 >= 3) begin
            chk("held_gap1", busy_rise[n0 + 1] - busy_rise[n0], N + 3);
            chk("held_gap2", busy_rise[n0 + 2] - busy_rise[n0 + 1], N + 3);
        end
        chk("held_done", done_total - d0, 3);
        chk("held_writes", wr_total - w0, 3 * N);

        // random canonical operands
        w0 = wr_total;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                mem_a[i] = 12'($urandom_range(3328));
                mem_b[i] = 12'($urandom_range(3328));
            end
            full_op($sformatf("rand%0d", k));
        end
        chk("rand_wr_total", wr_total - w0, 3 * N);
        chk("done_width_all", wide_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
